// File: rtl/mac_accum.sv
// Accumulates a host-programmed number of unsigned products into a wide sum and
// returns it on a valid/ready handshake. Define ACC_SAT_EN to saturate on overflow.
module mac_accum #(
  parameter int IPWRDLEN = 32,
  parameter int ACCWIDTH = 40,
  parameter int LENW     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LENW-1:0]     len,
  input  logic [IPWRDLEN-1:0] prod,
  input  logic                prod_valid,
  output logic                prod_ready,
  output logic [ACCWIDTH-1:0] acc_out,
  output logic                acc_valid,
  input  logic                acc_ready,
  output logic                busy,
  output logic                ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              state, state_nxt;
  logic [LENW-1:0]     count;
  logic [ACCWIDTH:0]   sum;
  logic                accept;

  assign accept     = prod_valid && (state == ACC);
  assign prod_ready = (state == ACC);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  // One extra bit holds the carry-out that flags overflow.
  assign sum = {1'b0, acc_out} + {{(ACCWIDTH+1-IPWRDLEN){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACC;
      ACC:     if (accept && count == LENW'(1)) state_nxt = DONE;
      DONE:    if (acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          acc_out <= '0;
          ovf     <= 1'b0;
          count   <= len;
        end
        ACC: if (accept) begin
          count <= count - LENW'(1);
          if (sum[ACCWIDTH]) ovf <= 1'b1;
`ifdef ACC_SAT_EN
          // All-ones plus any nonzero term carries again, so the clamp holds.
          acc_out <= sum[ACCWIDTH] ? {ACCWIDTH{1'b1}} : sum[ACCWIDTH-1:0];
`else
          acc_out <= sum[ACCWIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
